// File: rtl/twiddle_mult_scheduler.sv
// Twiddle-multiplier bank sequencer for the 64-point radix-2 DIF FFT.
// Streams 32 lower-leg samples per stage, maps each to twiddle index k and registers the product.
module twiddle_mult_scheduler #(
  parameter int LAST_STAGE = 5,
  parameter bit BYPASS_K0  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] IN_A32,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [31:0] MULT_A32,
  output logic [2:0]  MULT_CSEL,
  output logic [2:0]  MULT_TYPESEL,
  input  logic [31:0] MULT_R32,
  output logic [31:0] OUT_R32,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [2:0]  STAGE,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic [1:0]  STATE_DBG
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAST = 3'(LAST_STAGE);

  state_t      state;
  logic [4:0]  j;
  logic [2:0]  stage_q;
  logic [4:0]  k;
  logic        accept;

  // Valid/ready: a transfer happens on any cycle where valid and ready are both high.
  // Ready never looks at valid; the producer holds data and valid until the transfer.
  assign IN_READY = (state == RUN) && (!OUT_VALID || OUT_READY);
  assign accept   = IN_VALID && IN_READY;

  // The shift truncates to 5 bits, which is the modulo-32 wrap of the twiddle index.
  assign k            = j << stage_q;
  assign MULT_A32     = IN_A32;
  assign MULT_CSEL    = k[2:0];
  assign MULT_TYPESEL = {1'b0, k[4:3]};

  assign STAGE      = stage_q;
  assign BUSY       = (state == RUN) || (state == DRAIN);
  assign FRAME_DONE = (state == DONE);
  assign STATE_DBG  = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      j         <= 5'd0;
      stage_q   <= 3'd0;
      OUT_VALID <= 1'b0;
      OUT_R32   <= 32'd0;
    end else begin
      if (accept) begin
        OUT_R32   <= (BYPASS_K0 && (k == 5'd0)) ? IN_A32 : MULT_R32;
        OUT_VALID <= 1'b1;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (START) begin
            state   <= RUN;
            j       <= 5'd0;
            stage_q <= 3'd0;
          end
        end
        RUN: begin
          if (accept) begin
            j <= j + 5'd1;
            if (j == 5'd31) begin
              if (stage_q == LAST) state <= DRAIN;
              else stage_q <= stage_q + 3'd1;
            end
          end
        end
        DRAIN: begin
          // Leave only once the final product has been handed downstream.
          if (!OUT_VALID || OUT_READY) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
